// File: rtl/instruction_fetch_memory_pkg.sv
// Shared definitions for the instruction fetch memory: controller states,
// default geometry, the NOP word and the fetch-address fault rule.
package instruction_fetch_memory_pkg;

    localparam int DEFAULT_DEPTH = 256;
    localparam int DEFAULT_WIDTH = 32;

    localparam logic [DEFAULT_WIDTH-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } fetch_state_e;

    // Range is checked on the full 32-bit word index so high address bits
    // can never alias onto a valid word.
    function automatic logic isFetchFault(input logic [31:0] addr,
                                          input logic        byteAddr,
                                          input logic [31:0] depth);
        logic [31:0] idx;
        idx = byteAddr ? {2'b00, addr[31:2]} : addr;
        return (idx >= depth) || (byteAddr && (addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/instruction_fetch_memory_resp_queue.sv
// Two-entry response FIFO holding fetched words and their fault flags in
// request order; flush empties it in one cycle.
module fetch_resp_queue
    import instruction_fetch_memory_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pushFault,
    input  logic             pop,
    output logic             headValid,
    output logic [WIDTH-1:0] headData,
    output logic             headFault,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] dataReg [2];
    logic             faultReg [2];
    logic             wrPtrReg;
    logic             rdPtrReg;
    logic [1:0]       countReg;
    logic [1:0]       countNext;
    logic             pushEn;
    logic             popEn;

    assign popEn  = pop && (countReg != 2'd0);
    assign pushEn = push && ((countReg != 2'd2) || popEn);

    always_comb begin
        countNext = countReg;
        case ({pushEn, popEn})
            2'b10:   countNext = countReg + 2'd1;
            2'b01:   countNext = countReg - 2'd1;
            default: countNext = countReg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtrReg <= 1'b0;
            rdPtrReg <= 1'b0;
            countReg <= 2'd0;
        end else begin
            if (pushEn) begin
                wrPtrReg <= ~wrPtrReg;
            end
            if (popEn) begin
                rdPtrReg <= ~rdPtrReg;
            end
            countReg <= countNext;
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (pushEn && !(reset || flush)) begin
            dataReg[wrPtrReg]  <= pushData;
            faultReg[wrPtrReg] <= pushFault;
        end
    end

    assign headValid = (countReg != 2'd0);
    assign headData  = dataReg[rdPtrReg];
    assign headFault = faultReg[rdPtrReg];
    assign count     = countReg;

endmodule

// File: rtl/instruction_fetch_memory.sv
// Instruction memory with a clear/load controller on the write port and a
// 1-cycle-latency, 2-deep-buffered valid/ready fetch path on the read port.
module instruction_fetch_memory
    import instruction_fetch_memory_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit BYTE_ADDR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ReadAddress,
    input  logic             FetchValid,
    output logic             FetchReady,
    output logic [WIDTH-1:0] Instruction,
    output logic             InstrValid,
    input  logic             InstrReady,
    output logic             InstrFault,
    input  logic             Flush,
    input  logic             LoadStart,
    input  logic             LoadValid,
    input  logic [WIDTH-1:0] LoadData,
    input  logic             LoadLast,
    output logic             Loading,
    output logic             LoadOverflow
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              PW       = AW + 1;
    localparam logic [PW-1:0]   DEPTH_P  = PW'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] NOP     = WIDTH'(NOP_WORD);

    fetch_state_e     stateReg;
    logic [PW-1:0]    ptrReg;
    logic             overflowReg;
    logic             loadingReg;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ramDataReg;
    logic             wrEn;
    logic [AW-1:0]    wrAddr;
    logic [WIDTH-1:0] wrData;

    logic [AW-1:0]    rdIdx;
    logic             fetchFault;
    logic             fetchFire;
    logic             inflightReg;
    logic             inflightFaultReg;
    logic [WIDTH-1:0] inflightWord;
    logic [1:0]       occupancy;
    logic             dropAll;

    logic             qValid;
    logic [WIDTH-1:0] qData;
    logic             qFault;
    logic [1:0]       qCount;
    logic             qPush;
    logic             qPop;

    // Controller: CLEAR sweeps the pointer over every word, LOAD streams words in.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= ST_CLEAR;
            ptrReg      <= '0;
            overflowReg <= 1'b0;
            loadingReg  <= 1'b1;
        end else begin
            case (stateReg)
                ST_CLEAR: begin
                    if (ptrReg[AW-1:0] == LAST_IDX) begin
                        stateReg   <= ST_RUN;
                        ptrReg     <= '0;
                        loadingReg <= 1'b0;
                    end else begin
                        ptrReg <= ptrReg + PW'(1);
                    end
                end
                ST_RUN: begin
                    if (LoadStart) begin
                        stateReg    <= ST_LOAD;
                        ptrReg      <= '0;
                        overflowReg <= 1'b0;
                        loadingReg  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (LoadStart) begin
                        ptrReg      <= '0;
                        overflowReg <= 1'b0;
                    end else if (LoadValid) begin
                        if (ptrReg == DEPTH_P) begin
                            overflowReg <= 1'b1;
                        end else begin
                            ptrReg <= ptrReg + PW'(1);
                        end
                        if (LoadLast) begin
                            stateReg   <= ST_RUN;
                            loadingReg <= 1'b0;
                        end
                    end
                end
                default: begin
                    stateReg   <= ST_CLEAR;
                    ptrReg     <= '0;
                    loadingReg <= 1'b1;
                end
            endcase
        end
    end

    assign Loading      = loadingReg;
    assign LoadOverflow = overflowReg;

    assign wrEn = !reset &&
                  ((stateReg == ST_CLEAR) ||
                   ((stateReg == ST_LOAD) && LoadValid && !LoadStart && (ptrReg != DEPTH_P)));
    assign wrAddr = ptrReg[AW-1:0];
    assign wrData = (stateReg == ST_CLEAR) ? NOP : LoadData;

    // Writes only happen outside RUN and reads only inside it, so the two
    // ports never touch the same word in the same cycle.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        if (fetchFire) begin
            ramDataReg <= mem[rdIdx];
        end
    end

    assign rdIdx      = BYTE_ADDR ? ReadAddress[AW+1:2] : ReadAddress[AW-1:0];
    assign fetchFault = isFetchFault(ReadAddress, BYTE_ADDR, 32'(DEPTH));

    assign occupancy  = qCount + {1'b0, inflightReg};
    assign dropAll    = Flush || ((stateReg == ST_RUN) && LoadStart);
    assign FetchReady = (stateReg == ST_RUN) && !LoadStart &&
                        (Flush || (occupancy < 2'd2));
    assign fetchFire  = FetchValid && FetchReady;

    // A fetch accepted in a Flush cycle becomes the new in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflightReg      <= 1'b0;
            inflightFaultReg <= 1'b0;
        end else begin
            inflightReg <= fetchFire;
            if (fetchFire) begin
                inflightFaultReg <= fetchFault;
            end
        end
    end

    assign inflightWord = inflightFaultReg ? NOP : ramDataReg;

    // The in-flight word bypasses the queue when nothing is ahead of it and
    // the consumer takes it; otherwise it parks in the queue.
    assign qPop  = qValid && InstrReady;
    assign qPush = inflightReg && (qValid || !InstrReady);

    fetch_resp_queue #(
        .WIDTH(WIDTH)
    ) u_resp_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (dropAll),
        .push      (qPush),
        .pushData  (inflightWord),
        .pushFault (inflightFaultReg),
        .pop       (qPop),
        .headValid (qValid),
        .headData  (qData),
        .headFault (qFault),
        .count     (qCount)
    );

    always_comb begin
        InstrValid  = 1'b0;
        Instruction = NOP;
        InstrFault  = 1'b0;
        if (qValid) begin
            InstrValid  = 1'b1;
            Instruction = qData;
            InstrFault  = qFault;
        end else if (inflightReg) begin
            InstrValid  = 1'b1;
            Instruction = inflightWord;
            InstrFault  = inflightFaultReg;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed bench: instance 0 is DEPTH=256 word-addressed, instance 1 is
// DEPTH=8 byte-addressed, instance 2 is DEPTH=4 word-addressed.
module tb_instruction_fetch_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [3];
    logic [31:0] addr    [3];
    logic        fv      [3];
    logic        fr      [3];
    logic [31:0] instr   [3];
    logic        iv      [3];
    logic        ir      [3];
    logic        ifault  [3];
    logic        flush   [3];
    logic        ls      [3];
    logic        lv      [3];
    logic [31:0] ld      [3];
    logic        ll      [3];
    logic        loading [3];
    logic        ovf     [3];

    int nTests = 0;
    int nFail  = 0;

    logic [31:0] prog [6];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        instruction_fetch_memory #(
            .DEPTH     (gi == 0 ? 256 : (gi == 1 ? 8 : 4)),
            .WIDTH     (32),
            .BYTE_ADDR (gi == 1)
        ) dut (
            .clk          (clk),
            .reset        (rst[gi]),
            .ReadAddress  (addr[gi]),
            .FetchValid   (fv[gi]),
            .FetchReady   (fr[gi]),
            .Instruction  (instr[gi]),
            .InstrValid   (iv[gi]),
            .InstrReady   (ir[gi]),
            .InstrFault   (ifault[gi]),
            .Flush        (flush[gi]),
            .LoadStart    (ls[gi]),
            .LoadValid    (lv[gi]),
            .LoadData     (ld[gi]),
            .LoadLast     (ll[gi]),
            .Loading      (loading[gi]),
            .LoadOverflow (ovf[gi])
        );
    end

    function automatic int depthOf(input int d);
        return (d == 0) ? 256 : ((d == 1) ? 8 : 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one fetch with InstrReady=1 and returns the response and the
    // number of cycles from acceptance to InstrValid (0 on timeout).
    task automatic fetch_one(input int d, input logic [31:0] a,
                             output logic [31:0] data, output logic flt, output int lat);
        logic acc;
        acc   = 1'b0;
        lat   = 0;
        data  = 32'hxxxx_xxxx;
        flt   = 1'bx;
        fv[d] = 1'b1;
        addr[d] = a;
        ir[d] = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (fr[d] === 1'b1) acc = 1'b1;
            tick();
        end
        fv[d] = 1'b0;
        if (acc) begin
            for (int i = 1; i <= 20 && lat == 0; i++) begin
                @(negedge clk);
                if (iv[d] === 1'b1) begin
                    lat  = i;
                    data = instr[d];
                    flt  = ifault[d];
                end
                tick();
            end
        end
        $display("[TB] fetch dut%0d addr=%h -> data=%h fault=%b latency=%0d", d, a, data, flt, lat);
    endtask

    task automatic load_prog(input int d, input int n);
        ls[d] = 1'b1;
        tick();
        ls[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            lv[d] = 1'b1;
            ld[d] = prog[i];
            ll[d] = (i == n - 1);
            tick();
            $display("[TB] load dut%0d word%0d=%h last=%b", d, i, prog[i], (i == n - 1));
        end
        lv[d] = 1'b0;
        ll[d] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int loadCnt [3];
        int firstReady [3];
        logic [31:0] data;
        logic flt;
        int lat;
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            nTests++;
            if (loading[d] !== 1'b1 || fr[d] !== 1'b0 || iv[d] !== 1'b0 ||
                instr[d] !== 32'h0 || ifault[d] !== 1'b0 || ovf[d] !== 1'b0) begin
                nFail++;
                $display("FAIL reset_state dut%0d: Loading=%b FetchReady=%b InstrValid=%b Instruction=%h InstrFault=%b LoadOverflow=%b, required 1 0 0 00000000 0 0",
                         d, loading[d], fr[d], iv[d], instr[d], ifault[d], ovf[d]);
            end
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0;
            loadCnt[d] = 0;
            firstReady[d] = 0;
        end
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (loading[d] === 1'b1) loadCnt[d]++;
                if (fr[d] === 1'b1 && firstReady[d] == 0) firstReady[d] = c;
            end
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            nTests++;
            if (loadCnt[d] != depthOf(d) || firstReady[d] != depthOf(d) + 1) begin
                nFail++;
                $display("FAIL clear_timing dut%0d: Loading cycles=%0d FetchReady first cycle=%0d, required %0d and %0d",
                         d, loadCnt[d], firstReady[d], depthOf(d), depthOf(d) + 1);
            end
        end
        fetch_one(0, 32'd5, data, flt, lat);
        nTests++;
        if (data !== 32'h0 || flt !== 1'b0 || lat != 1) begin
            nFail++;
            $display("FAIL cleared_word: data=%h fault=%b latency=%0d, required 00000000 0 1", data, flt, lat);
        end
    endtask

    task automatic test_load_readback();
        load_prog(0, 6);
        @(negedge clk);
        nTests++;
        if (loading[0] !== 1'b0 || ovf[0] !== 1'b0) begin
            nFail++;
            $display("FAIL load_done: Loading=%b LoadOverflow=%b, required 0 0", loading[0], ovf[0]);
        end
        tick();
        ir[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            fv[0]   = (c < 6);
            addr[0] = 32'(c);
            @(negedge clk);
            if (c < 6) begin
                nTests++;
                if (fr[0] !== 1'b1) begin
                    nFail++;
                    $display("FAIL b2b_ready cycle%0d: FetchReady=%b, required 1", c, fr[0]);
                end
            end
            if (c >= 1 && c <= 6) begin
                nTests++;
                if (iv[0] !== 1'b1 || instr[0] !== prog[c-1] || ifault[0] !== 1'b0) begin
                    nFail++;
                    $display("FAIL b2b_word cycle%0d: valid=%b data=%h fault=%b, required 1 %h 0",
                             c, iv[0], instr[0], ifault[0], prog[c-1]);
                end
            end
            if (c == 7) begin
                nTests++;
                if (iv[0] !== 1'b0) begin
                    nFail++;
                    $display("FAIL b2b_drain: InstrValid=%b, required 0", iv[0]);
                end
            end
            tick();
        end
        fv[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0]  fvPat;
        logic [7:0]  irPat;
        logic [7:0]  frExp;
        logic [7:0]  ivExp;
        logic [31:0] addrs [8];
        logic [31:0] expW  [8];
        fvPat = 8'b0011_1111;
        irPat = 8'b1111_0000;
        frExp = 8'b1110_0011;
        ivExp = 8'b0111_1110;
        addrs = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0};
        expW  = '{32'h0, prog[0], prog[0], prog[0], prog[0], prog[1], prog[2], 32'h0};
        for (int c = 0; c < 8; c++) begin
            fv[0]   = fvPat[c];
            ir[0]   = irPat[c];
            addr[0] = addrs[c];
            @(negedge clk);
            nTests++;
            if (fr[0] !== frExp[c] || iv[0] !== ivExp[c] ||
                (ivExp[c] && (instr[0] !== expW[c] || ifault[0] !== 1'b0))) begin
                nFail++;
                $display("FAIL backpressure cycle%0d: FetchReady=%b InstrValid=%b data=%h fault=%b, required %b %b %h 0",
                         c, fr[0], iv[0], instr[0], ifault[0], frExp[c], ivExp[c], expW[c]);
            end
            tick();
        end
        fv[0] = 1'b0;
        ir[0] = 1'b1;
    endtask

    task automatic test_fault();
        logic [31:0] data;
        logic flt;
        int lat;
        fetch_one(0, 32'd256, data, flt, lat);
        nTests++;
        if (data !== 32'h0 || flt !== 1'b1 || lat != 1) begin
            nFail++;
            $display("FAIL range_256: data=%h fault=%b latency=%0d, required 00000000 1 1", data, flt, lat);
        end
        fetch_one(0, 32'h8000_0003, data, flt, lat);
        nTests++;
        if (data !== 32'h0 || flt !== 1'b1 || lat != 1) begin
            nFail++;
            $display("FAIL range_highbits: data=%h fault=%b latency=%0d, required 00000000 1 1", data, flt, lat);
        end
        fetch_one(0, 32'd255, data, flt, lat);
        nTests++;
        if (data !== 32'h0 || flt !== 1'b0 || lat != 1) begin
            nFail++;
            $display("FAIL range_last: data=%h fault=%b latency=%0d, required 00000000 0 1", data, flt, lat);
        end
        fetch_one(0, 32'd4, data, flt, lat);
        nTests++;
        if (data !== prog[4] || flt !== 1'b0 || lat != 1) begin
            nFail++;
            $display("FAIL after_fault: data=%h fault=%b latency=%0d, required %h 0 1", data, flt, lat, prog[4]);
        end
    endtask

    task automatic test_flush();
        logic [5:0]  fvPat;
        logic [5:0]  flPat;
        logic [5:0]  irPat;
        logic [5:0]  frExp;
        logic [5:0]  ivExp;
        logic [31:0] addrs [6];
        logic [31:0] expW  [6];
        fvPat = 6'b000111;
        flPat = 6'b000100;
        irPat = 6'b111000;
        frExp = 6'b111111;
        ivExp = 6'b001110;
        addrs = '{32'd0, 32'd1, 32'd4, 32'd0, 32'd0, 32'd0};
        expW  = '{32'h0, prog[0], prog[0], prog[4], 32'h0, 32'h0};
        for (int c = 0; c < 6; c++) begin
            fv[0]    = fvPat[c];
            flush[0] = flPat[c];
            ir[0]    = irPat[c];
            addr[0]  = addrs[c];
            @(negedge clk);
            nTests++;
            if (fr[0] !== frExp[c] || iv[0] !== ivExp[c] ||
                (ivExp[c] && (instr[0] !== expW[c] || ifault[0] !== 1'b0))) begin
                nFail++;
                $display("FAIL flush cycle%0d: FetchReady=%b InstrValid=%b data=%h fault=%b, required %b %b %h 0",
                         c, fr[0], iv[0], instr[0], ifault[0], frExp[c], ivExp[c], expW[c]);
            end
            tick();
        end
        fv[0]    = 1'b0;
        flush[0] = 1'b0;
        ir[0]    = 1'b1;
    endtask

    task automatic test_byte_addr();
        logic [31:0] data;
        logic flt;
        int lat;
        load_prog(1, 6);
        fetch_one(1, 32'h6, data, flt, lat);
        nTests++;
        if (data !== 32'h0 || flt !== 1'b1 || lat != 1) begin
            nFail++;
            $display("FAIL byte_misaligned: data=%h fault=%b latency=%0d, required 00000000 1 1", data, flt, lat);
        end
        fetch_one(1, 32'h8, data, flt, lat);
        nTests++;
        if (data !== prog[2] || flt !== 1'b0 || lat != 1) begin
            nFail++;
            $display("FAIL byte_word2: data=%h fault=%b latency=%0d, required %h 0 1", data, flt, lat, prog[2]);
        end
        fetch_one(1, 32'h20, data, flt, lat);
        nTests++;
        if (data !== 32'h0 || flt !== 1'b1 || lat != 1) begin
            nFail++;
            $display("FAIL byte_range: data=%h fault=%b latency=%0d, required 00000000 1 1", data, flt, lat);
        end
        fetch_one(1, 32'h14, data, flt, lat);
        nTests++;
        if (data !== prog[5] || flt !== 1'b0 || lat != 1) begin
            nFail++;
            $display("FAIL byte_word5: data=%h fault=%b latency=%0d, required %h 0 1", data, flt, lat, prog[5]);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] data;
        logic flt;
        int lat;
        load_prog(2, 5);
        @(negedge clk);
        nTests++;
        if (ovf[2] !== 1'b1 || loading[2] !== 1'b0) begin
            nFail++;
            $display("FAIL overflow_flag: LoadOverflow=%b Loading=%b, required 1 0", ovf[2], loading[2]);
        end
        tick();
        fetch_one(2, 32'd0, data, flt, lat);
        nTests++;
        if (data !== prog[0] || flt !== 1'b0 || lat != 1) begin
            nFail++;
            $display("FAIL overflow_word0: data=%h fault=%b latency=%0d, required %h 0 1", data, flt, lat, prog[0]);
        end
        fetch_one(2, 32'd3, data, flt, lat);
        nTests++;
        if (data !== prog[3] || flt !== 1'b0 || lat != 1) begin
            nFail++;
            $display("FAIL overflow_word3: data=%h fault=%b latency=%0d, required %h 0 1", data, flt, lat, prog[3]);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] data;
        logic flt;
        int lat;
        ls[2] = 1'b1;
        tick();
        ls[2] = 1'b0;
        @(negedge clk);
        nTests++;
        if (ovf[2] !== 1'b0 || loading[2] !== 1'b1) begin
            nFail++;
            $display("FAIL loadstart_clears: LoadOverflow=%b Loading=%b, required 0 1", ovf[2], loading[2]);
        end
        lv[2] = 1'b1;
        ld[2] = 32'hDEAD_BEEF;
        ll[2] = 1'b0;
        tick();
        tick();
        rst[2] = 1'b1;
        lv[2]  = 1'b0;
        tick();
        @(negedge clk);
        nTests++;
        if (loading[2] !== 1'b1 || fr[2] !== 1'b0 || ovf[2] !== 1'b0 || iv[2] !== 1'b0) begin
            nFail++;
            $display("FAIL midload_reset: Loading=%b FetchReady=%b LoadOverflow=%b InstrValid=%b, required 1 0 0 0",
                     loading[2], fr[2], ovf[2], iv[2]);
        end
        tick();
        rst[2] = 1'b0;
        for (int w = 0; w < 4; w++) begin
            fetch_one(2, 32'(w), data, flt, lat);
            nTests++;
            if (data !== 32'h0 || flt !== 1'b0 || lat != 1) begin
                nFail++;
                $display("FAIL rezero_word%0d: data=%h fault=%b latency=%0d, required 00000000 0 1", w, data, flt, lat);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        prog = '{32'h20090004, 32'h200A0004, 32'h112A0003,
                 32'h00000000, 32'h012A5824, 32'h012A5825};
        for (int d = 0; d < 3; d++) begin
            rst[d]   = 1'b1;
            addr[d]  = 32'h0;
            fv[d]    = 1'b0;
            ir[d]    = 1'b1;
            flush[d] = 1'b0;
            ls[d]    = 1'b0;
            lv[d]    = 1'b0;
            ld[d]    = 32'h0;
            ll[d]    = 1'b0;
        end
        test_reset();
        test_load_readback();
        test_backpressure();
        test_fault();
        test_flush();
        test_byte_addr();
        test_overflow();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
